// File: rtl/dmemory_ctrl.sv
// dmemory_ctrl: byte-addressable 32-bit data memory with a word-wide programming port (PROG/RUN modes).
// Latency: stores commit on the accepting edge; loads return readData/rdata_valid one cycle after acceptance.
// Backpressure: none; mem_ready advertises RUN and requests outside RUN are dropped. Optional macro: DMEM_ALIGN_CHECK_EN.
module dmemory_ctrl #(
    parameter int ADDR_WIDTH     = 14,
    parameter int UPG_ADDR_WIDTH = 14
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      mem_req,
    input  logic                      mem_we,
    input  logic [1:0]                mem_size,
    input  logic                      mem_unsigned,
    input  logic [31:0]               address,
    input  logic [31:0]               writeData,
    output logic [31:0]               readData,
    output logic                      rdata_valid,
    output logic                      mem_ready,
    output logic                      misalign,
    input  logic                      upg_mode_i,
    input  logic                      upg_wen_i,
    input  logic [UPG_ADDR_WIDTH-1:0] upg_adr_i,
    input  logic [31:0]               upg_dat_i,
    input  logic                      upg_done_i
);
    typedef enum logic {PROG, RUN} state_t;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    state_t                state, state_nxt;
    logic [31:0]           mem [DEPTH];
    logic                  accepted, out_of_range, mis;
    logic [ADDR_WIDTH-1:0] word_idx, wr_idx;
    logic [31:0]           rd_word, load_val, st_dat, wr_dat;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [3:0]            st_be, wr_be;
    logic                  wr_en;

    assign accepted     = mem_req && (state == RUN);
    assign word_idx     = address[ADDR_WIDTH+1:2];
    assign out_of_range = |(address >> (ADDR_WIDTH + 2));

`ifdef DMEM_ALIGN_CHECK_EN
    assign mis = (mem_size == 2'b01) ? address[0]
               : (mem_size[1] ? (address[1:0] != 2'b00) : 1'b0);
`else
    assign mis = 1'b0;
`endif

    assign rd_word = mem[word_idx];
    assign rd_byte = rd_word[{address[1:0], 3'b000} +: 8];
    assign rd_half = address[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_val = rd_word;
        case (mem_size)
            2'b00:   load_val = mem_unsigned ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   load_val = mem_unsigned ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: load_val = rd_word;
        endcase
    end

    // Replicate store data across lanes so the byte enables alone pick the destination.
    always_comb begin
        st_be  = 4'b1111;
        st_dat = writeData;
        case (mem_size)
            2'b00: begin
                st_be  = 4'b0001 << address[1:0];
                st_dat = {4{writeData[7:0]}};
            end
            2'b01: begin
                st_be  = address[1] ? 4'b1100 : 4'b0011;
                st_dat = {2{writeData[15:0]}};
            end
            default: ;
        endcase
    end

    // Single write port: programming port owns it in PROG, the CPU in RUN.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = word_idx;
        wr_be  = st_be;
        wr_dat = st_dat;
        if (state == PROG) begin
            wr_en  = upg_wen_i;
            wr_idx = ADDR_WIDTH'(upg_adr_i);
            wr_be  = 4'b1111;
            wr_dat = upg_dat_i;
        end else begin
            wr_en  = accepted && mem_we && !out_of_range && !mis;
        end
        if (reset) wr_en = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_dat[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            PROG:    if (upg_done_i || !upg_mode_i) state_nxt = RUN;
            default: if (upg_mode_i && !upg_done_i) state_nxt = PROG;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= PROG;
            readData    <= 32'b0;
            rdata_valid <= 1'b0;
            misalign    <= 1'b0;
            mem_ready   <= 1'b0;
        end else begin
            state       <= state_nxt;
            mem_ready   <= (state_nxt == RUN);
            rdata_valid <= accepted && (!mem_we || mis);
            misalign    <= accepted && mis;
            if (accepted && (!mem_we || mis)) begin
                readData <= (mis || out_of_range) ? 32'b0 : load_val;
            end
        end
    end
endmodule

// File: tb/tb_dmemory_ctrl.sv
// Directed bench for dmemory_ctrl: stimulus pushes expected load results, a negedge monitor pops and compares.
module tb_dmemory_ctrl;
    logic        clock = 1'b0;
    logic        reset, mem_req, mem_we, mem_unsigned;
    logic [1:0]  mem_size;
    logic [31:0] address, writeData, readData, upg_dat_i;
    logic        rdata_valid, mem_ready, misalign;
    logic        upg_mode_i, upg_wen_i, upg_done_i;
    logic [13:0] upg_adr_i;

    typedef struct packed {
        logic [31:0] data;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    dmemory_ctrl #(.ADDR_WIDTH(14), .UPG_ADDR_WIDTH(14)) dut (
        .clock(clock), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .address(address),
        .writeData(writeData), .readData(readData), .rdata_valid(rdata_valid),
        .mem_ready(mem_ready), .misalign(misalign), .upg_mode_i(upg_mode_i),
        .upg_wen_i(upg_wen_i), .upg_adr_i(upg_adr_i), .upg_dat_i(upg_dat_i),
        .upg_done_i(upg_done_i)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (rdata_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rdata_valid: got readData 0x%08h with no load outstanding", readData);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("load_data", readData, e.data);
                check("load_misalign", {31'b0, misalign}, {31'b0, e.mis});
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic access(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] data);
        mem_req = 1'b1; mem_we = we; address = addr; mem_size = size;
        mem_unsigned = uns; writeData = data;
        step();
        mem_req = 1'b0;
    endtask

    task automatic load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                        input logic [31:0] exp_data, input logic exp_mis);
        exp_t e;
        e.data = exp_data;
        e.mis  = exp_mis;
        exp_q.push_back(e);
        access(1'b0, addr, size, uns, 32'h0);
    endtask

    task automatic store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data);
        access(1'b1, addr, size, 1'b0, data);
    endtask

    task automatic prog(input logic [13:0] adr, input logic [31:0] dat);
        upg_wen_i = 1'b1; upg_adr_i = adr; upg_dat_i = dat;
        step();
        upg_wen_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'b10; mem_unsigned = 1'b0;
        address = '0; writeData = '0; upg_mode_i = 1'b1; upg_wen_i = 1'b0;
        upg_adr_i = '0; upg_dat_i = '0; upg_done_i = 1'b0;
        step(); step();
        check("reset_mem_ready", {31'b0, mem_ready}, 32'd0);
        check("reset_rdata_valid", {31'b0, rdata_valid}, 32'd0);
        check("reset_readData", readData, 32'd0);
        check("reset_misalign", {31'b0, misalign}, 32'd0);
        reset = 1'b0;

        prog(14'd5, 32'h1234_5678);
        check("prog_stays_prog", {31'b0, mem_ready}, 32'd0);
        access(1'b0, 32'h14, 2'b10, 1'b0, 32'h0);
        check("prog_ignores_cpu", {31'b0, rdata_valid}, 32'd0);
        prog(14'd4, 32'hA5A5_0F0F);
        prog(14'd6, 32'h1111_1111);
        prog(14'd8, 32'h0000_0000);
        prog(14'd0, 32'hCAFE_F00D);
        upg_done_i = 1'b1;
        step();
        check("done_enters_run", {31'b0, mem_ready}, 32'd1);
        upg_done_i = 1'b0; upg_mode_i = 1'b0;

        load(32'h14, 2'b10, 1'b0, 32'h1234_5678, 1'b0);
        store(32'h15, 2'b00, 32'h0000_0080);
        load(32'h15, 2'b00, 1'b0, 32'hFFFF_FF80, 1'b0);
        load(32'h15, 2'b00, 1'b1, 32'h0000_0080, 1'b0);
        load(32'h14, 2'b10, 1'b0, 32'h1234_8078, 1'b0);
        load(32'h16, 2'b00, 1'b0, 32'h0000_0034, 1'b0);
        load(32'h17, 2'b00, 1'b0, 32'h0000_0012, 1'b0);
        load(32'h14, 2'b01, 1'b0, 32'hFFFF_8078, 1'b0);
        store(32'h22, 2'b01, 32'h0000_BEEF);
        load(32'h22, 2'b01, 1'b0, 32'hFFFF_BEEF, 1'b0);
        load(32'h22, 2'b01, 1'b1, 32'h0000_BEEF, 1'b0);
        load(32'h20, 2'b10, 1'b0, 32'hBEEF_0000, 1'b0);
        store(32'h0001_0000, 2'b10, 32'hFFFF_FFFF);
        load(32'h0001_0000, 2'b10, 1'b0, 32'h0000_0000, 1'b0);
        load(32'h0, 2'b10, 1'b0, 32'hCAFE_F00D, 1'b0);

        prog(14'd6, 32'h2222_2222);
        load(32'h18, 2'b10, 1'b0, 32'h1111_1111, 1'b0);

`ifdef DMEM_ALIGN_CHECK_EN
        load(32'h13, 2'b10, 1'b0, 32'h0000_0000, 1'b1);
        begin
            exp_t e;
            e.data = 32'h0;
            e.mis  = 1'b1;
            exp_q.push_back(e);
        end
        store(32'h11, 2'b01, 32'h0000_7777);
        load(32'h10, 2'b10, 1'b0, 32'hA5A5_0F0F, 1'b0);
`else
        load(32'h13, 2'b10, 1'b0, 32'hA5A5_0F0F, 1'b0);
`endif
        step();
        check("readData_holds", readData, 32'hA5A5_0F0F);

        upg_mode_i = 1'b1;
        load(32'h14, 2'b10, 1'b0, 32'h1234_8078, 1'b0);
        check("mode_rise_not_ready", {31'b0, mem_ready}, 32'd0);
        upg_mode_i = 1'b0;
        step();
        check("mode_fall_ready", {31'b0, mem_ready}, 32'd1);

        reset = 1'b1;
        access(1'b0, 32'h14, 2'b10, 1'b0, 32'h0);
        check("reset_cancels_load", {31'b0, rdata_valid}, 32'd0);
        check("reset_clears_ready", {31'b0, mem_ready}, 32'd0);
        reset = 1'b0;
        step();
        check("run_after_reset", {31'b0, mem_ready}, 32'd1);
        load(32'h14, 2'b10, 1'b0, 32'h1234_8078, 1'b0);
        step(); step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dmemory_ctrl.md
DMEMORY_CTRL -- requirements
Module: dmemory_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 14, word-address bits; depth SHALL be 2**ADDR_WIDTH 32-bit words.
REQ-002 Parameter UPG_ADDR_WIDTH, default 14, programming-port word-address bits; SHALL be <= ADDR_WIDTH.
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 mem_req  in  1  CPU access request, one access per cycle.
REQ-006 mem_we  in  1  1 = store, 0 = load; qualified by mem_req.
REQ-007 mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-008 mem_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend.
REQ-009 address  in  32  CPU byte address.
REQ-010 writeData  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 readData  out  32  extended load data, valid when rdata_valid=1.
REQ-012 rdata_valid  out  1  one-cycle pulse per accepted load.
REQ-013 mem_ready  out  1  1 in RUN state only.
REQ-014 misalign  out  1  one-cycle fault pulse, aligned with rdata_valid slot.
REQ-015 upg_mode_i  in  1  1 = programming mode requested.
REQ-016 upg_wen_i  in  1  programming word write enable.
REQ-017 upg_adr_i  in  UPG_ADDR_WIDTH  programming word address.
REQ-018 upg_dat_i  in  32  programming write data.
REQ-019 upg_done_i  in  1  programming finished.

Function
REQ-020 FSM states PROG and RUN; PROG->RUN when upg_done_i=1 or upg_mode_i=0; RUN->PROG when upg_mode_i=1 and upg_done_i=0; transition takes effect next cycle.
REQ-021 In PROG, CPU requests SHALL be ignored; upg_wen_i=1 SHALL write upg_dat_i to word upg_adr_i (zero-extended to ADDR_WIDTH).
REQ-022 In RUN, upg_wen_i SHALL be ignored; accepted access = mem_req=1 in RUN.
REQ-023 Word index = address[ADDR_WIDTH+1:2]; lane = address[1:0].
REQ-024 Byte store writes writeData[7:0] to lane address[1:0] only; half store writes writeData[15:0] to half address[1]; word store writes all lanes.
REQ-025 Load latency exactly 1 cycle: readData/rdata_valid registered on the edge after acceptance.
REQ-026 Load data extracted from addressed lane(s) and sign- or zero-extended per mem_unsigned sampled at acceptance.
REQ-027 Stores produce no rdata_valid; load one cycle after store to same word returns new data.
REQ-028 Out-of-range (any address[31:ADDR_WIDTH+2] bit set): store dropped; load returns 0 with rdata_valid=1.
REQ-029 Load accepted in last RUN cycle before RUN->PROG SHALL still complete with rdata_valid next cycle.
REQ-030 readData SHALL hold its last value when rdata_valid=0.

Reset
REQ-031 reset SHALL force state PROG, readData=0, rdata_valid=0, misalign=0, mem_ready=0; reset dominates all other inputs in the same cycle.
REQ-032 Memory contents SHALL NOT be altered by reset; reset mid-load SHALL cancel the pending rdata_valid.

Configuration
REQ-033 Macro DMEM_ALIGN_CHECK_EN defined: half access with address[0]=1 or word access with address[1:0]!=0 SHALL suppress the store, return readData=0, pulse misalign=1 and rdata_valid=1 (loads and stores) one cycle later.
REQ-034 Macro undefined: half ignores address[0], word ignores address[1:0]; misalign tied 0.

Verification
REQ-035 Reset, upg_mode_i=1, upg_wen_i writes 0x12345678 to word 5, upg_done_i=1 -> mem_ready=1 next cycle; load word 0x14 -> readData=0x12345678, rdata_valid=1 one cycle later.
REQ-036 RUN, byte store 0x80 to 0x15, then signed byte load 0x15 -> 0xFFFFFF80; unsigned -> 0x00000080; word load 0x14 -> 0x12348078.
REQ-037 RUN, half store 0xBEEF to 0x22, signed half load 0x22 -> 0xFFFFBEEF; store to 0x00010000 (ADDR_WIDTH=14) then load -> 0, memory unchanged.
REQ-038 With DMEM_ALIGN_CHECK_EN, word load at 0x13 -> misalign=1, readData=0; without, returns word at 0x10, misalign=0.
REQ-039 Load issued same cycle upg_mode_i rises -> rdata_valid next cycle with correct data, mem_ready=0; reset asserted in that cycle instead -> rdata_valid=0.
